// File: rtl/accel_pkg.sv
// Shared constants and types for the accelerator AXI4-Stream output stage.
package accel_pkg;

  localparam int unsigned AXIS_DATA_W = 32;
  localparam int unsigned AXIS_STRB_W = AXIS_DATA_W / 8;
  localparam int unsigned AXIS_ID_W   = 8;
  localparam int unsigned AXIS_DEST_W = 4;
  localparam int unsigned AXIS_USER_W = 8;
  localparam int unsigned SEQ_W       = 8;
  localparam int unsigned LEN_W       = 16;

  localparam logic [AXIS_STRB_W-1:0] TSTRB_ALL = '1;
  localparam logic [AXIS_STRB_W-1:0] TKEEP_ALL = '1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend
  } state_e;

endpackage

// File: rtl/accel_sync_fifo.sv
// Synchronous FIFO with occupancy count; head word is visible on o_rd_data, no fall-through.
module accel_sync_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [Width-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [Width-1:0]           o_rd_data,
  output logic [$clog2(Depth):0]     o_count,
  output logic                       o_empty
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;

  assign w_full    = (r_count == CW'(Depth));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_wr      = i_wr_en && !w_full;
  assign w_rd      = i_rd_en && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_rd) begin
        r_count <= r_count + CW'(1);
      end else if (w_rd && !w_wr) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/accel_axis_packetizer.sv
// Buffers accelerator result words and emits them as AXI4-Stream packets with TLAST/TID/TDEST/TUSER.
// Optional packet/word statistics counters: define ACCEL_AXIS_PKT_STATS_EN.
module accel_axis_packetizer
  import accel_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DATA_WIDTH = AXIS_DATA_W,
  parameter int unsigned ID_WIDTH   = AXIS_ID_W,
  parameter int unsigned DEST_WIDTH = AXIS_DEST_W,
  parameter int unsigned USER_WIDTH = AXIS_USER_W
) (
  input  logic                   m00_axis_aclk,
  input  logic                   m00_axis_aresetn,
  input  logic                   cfg_enable,
  input  logic [LEN_W-1:0]       cfg_pkt_len,
  input  logic [ID_WIDTH-1:0]    cfg_tid,
  input  logic [DEST_WIDTH-1:0]  cfg_tdest,
  input  logic                   res_valid,
  input  logic [DATA_WIDTH-1:0]  res_data,
  output logic                   res_ready,
  output logic                   m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0]  m00_axis_tdata,
  output logic [AXIS_STRB_W-1:0] m00_axis_tstrb,
  output logic [AXIS_STRB_W-1:0] m00_axis_tkeep,
  output logic                   m00_axis_tlast,
  output logic [ID_WIDTH-1:0]    m00_axis_tid,
  output logic [DEST_WIDTH-1:0]  m00_axis_tdest,
  output logic [USER_WIDTH-1:0]  m00_axis_tuser,
  input  logic                   m00_axis_tready,
  output logic                   sts_busy,
  output logic                   sts_pkt_done
`ifdef ACCEL_AXIS_PKT_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [31:0]            sts_pkt_count,
  output logic [31:0]            sts_word_count
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e                 r_state;
  state_e                 w_state_next;
  logic                   r_ready_en;
  logic [LEN_W-1:0]       r_len;
  logic [LEN_W-1:0]       r_beat_cnt;
  logic [ID_WIDTH-1:0]    r_tid;
  logic [DEST_WIDTH-1:0]  r_tdest;
  logic [SEQ_W-1:0]       r_seq;
  logic                   r_tvalid;
  logic                   r_tlast;
  logic [DATA_WIDTH-1:0]  r_tdata;

  logic                   w_hs;
  logic                   w_pop;
  logic                   w_latch;
  logic                   w_seq_inc;
  logic                   w_fifo_wr;
  logic                   w_fifo_empty;
  logic [CNT_W-1:0]       w_fifo_count;
  logic [DATA_WIDTH-1:0]  w_fifo_rdata;

  // No full-bypass: a full FIFO stalls the core even when a pop happens this cycle.
  assign res_ready = r_ready_en && (w_fifo_count != CNT_W'(FIFO_DEPTH));
  assign w_fifo_wr = res_valid && res_ready;
  assign w_hs      = r_tvalid && m00_axis_tready;

  accel_sync_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DATA_WIDTH)
  ) u_fifo (
    .i_clk     (m00_axis_aclk),
    .i_rst_n   (m00_axis_aresetn),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (res_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_rdata),
    .o_count   (w_fifo_count),
    .o_empty   (w_fifo_empty)
  );

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_latch      = 1'b0;
    w_seq_inc    = 1'b0;
    case (r_state)
      StIdle: begin
        if (cfg_enable && !w_fifo_empty) begin
          w_latch      = 1'b1;
          w_state_next = StLoad;
        end
      end
      StLoad: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = StSend;
        end
      end
      StSend: begin
        if (w_hs) begin
          if (r_tlast) begin
            w_seq_inc    = 1'b1;
            w_state_next = StIdle;
          end else if (!w_fifo_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_next = StLoad;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_state    <= StIdle;
      r_ready_en <= 1'b0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_tid      <= '0;
      r_tdest    <= '0;
      r_seq      <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tdata    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ready_en <= 1'b1;
      if (w_latch) begin
        r_len      <= (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
        r_tid      <= cfg_tid;
        r_tdest    <= cfg_tdest;
        r_beat_cnt <= '0;
      end
      // beat_cnt tops out at len-1 on the last beat, so 65535 never wraps early.
      if (w_pop) begin
        r_tdata    <= w_fifo_rdata;
        r_tlast    <= (r_beat_cnt == r_len - LEN_W'(1));
        r_beat_cnt <= r_beat_cnt + LEN_W'(1);
        r_tvalid   <= 1'b1;
      end else if (w_hs) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      if (w_seq_inc) begin
        r_seq <= r_seq + SEQ_W'(1);
      end
    end
  end

  assign m00_axis_tvalid = r_tvalid;
  assign m00_axis_tdata  = r_tdata;
  assign m00_axis_tlast  = r_tlast;
  assign m00_axis_tid    = r_tid;
  assign m00_axis_tdest  = r_tdest;
  assign m00_axis_tuser  = USER_WIDTH'(r_seq);
  assign m00_axis_tstrb  = r_tvalid ? TSTRB_ALL : '0;
  assign m00_axis_tkeep  = r_tvalid ? TKEEP_ALL : '0;
  assign sts_busy        = (r_state != StIdle);
  assign sts_pkt_done    = w_hs && r_tlast;

`ifdef ACCEL_AXIS_PKT_STATS_EN
  logic [31:0] r_pkt_count;
  logic [31:0] r_word_count;

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_pkt_count  <= '0;
      r_word_count <= '0;
    end else if (stats_clr) begin
      r_pkt_count  <= '0;
      r_word_count <= '0;
    end else begin
      if (w_hs)         r_word_count <= r_word_count + 32'd1;
      if (sts_pkt_done) r_pkt_count  <= r_pkt_count + 32'd1;
    end
  end

  assign sts_pkt_count  = r_pkt_count;
  assign sts_word_count = r_word_count;
`endif

endmodule

// File: tb/tb_accel_axis_packetizer.sv
// Scoreboard bench for accel_axis_packetizer: directed pushes queue expected beats, a monitor checks them.
module tb_accel_axis_packetizer;

  logic        clk;
  logic        rst_n;
  logic        cfg_enable;
  logic [15:0] cfg_pkt_len;
  logic [7:0]  cfg_tid;
  logic [3:0]  cfg_tdest;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic [3:0]  tkeep;
  logic        tlast;
  logic [7:0]  tid;
  logic [3:0]  tdest;
  logic [7:0]  tuser;
  logic        tready;
  logic        sts_busy;
  logic        sts_pkt_done;
`ifdef ACCEL_AXIS_PKT_STATS_EN
  logic        stats_clr;
  logic [31:0] sts_pkt_count;
  logic [31:0] sts_word_count;
`endif

  accel_axis_packetizer u_dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .cfg_enable       (cfg_enable),
    .cfg_pkt_len      (cfg_pkt_len),
    .cfg_tid          (cfg_tid),
    .cfg_tdest        (cfg_tdest),
    .res_valid        (res_valid),
    .res_data         (res_data),
    .res_ready        (res_ready),
    .m00_axis_tvalid  (tvalid),
    .m00_axis_tdata   (tdata),
    .m00_axis_tstrb   (tstrb),
    .m00_axis_tkeep   (tkeep),
    .m00_axis_tlast   (tlast),
    .m00_axis_tid     (tid),
    .m00_axis_tdest   (tdest),
    .m00_axis_tuser   (tuser),
    .m00_axis_tready  (tready),
    .sts_busy         (sts_busy),
    .sts_pkt_done     (sts_pkt_done)
`ifdef ACCEL_AXIS_PKT_STATS_EN
    ,
    .stats_clr        (stats_clr),
    .sts_pkt_count    (sts_pkt_count),
    .sts_word_count   (sts_word_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [7:0]  user;
    logic [7:0]  id;
    logic [3:0]  dest;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   d0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic push(input logic [31:0] d, input logic last, input logic [7:0] user,
                      input logic [7:0] id, input logic [3:0] dest);
    exp_t e;
    logic acc;
    int   n;
    e.data = d; e.last = last; e.user = user; e.id = id; e.dest = dest;
    exp_q.push_back(e);
    res_valid = 1'b1;
    res_data  = d;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = res_ready;
      tick();
      n++;
    end
    if (!acc) chk("push_timeout", 64'(n), 64'd0);
    res_valid = 1'b0;
  endtask

  task automatic wait_tvalid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tvalid && n < 200);
    if (!tvalid) chk("wait_tvalid_timeout", 64'(tvalid), 64'd1);
    tick();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || tvalid) && n < 1000);
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  // Monitor: compare every handshaked beat against the scoreboard and check stall stability.
  initial begin : monitor
    exp_t        e;
    logic        prev_stall;
    logic [31:0] h_data;
    logic        h_last;
    logic [7:0]  h_user;
    prev_stall = 1'b0;
    h_data = '0; h_last = 1'b0; h_user = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_tvalid_held", 64'(tvalid), 64'd1);
          chk("stall_tdata", 64'(tdata), 64'(h_data));
          chk("stall_tlast", 64'(tlast), 64'(h_last));
          chk("stall_tuser", 64'(tuser), 64'(h_user));
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat actual=%0h required=none", tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_tdata", 64'(tdata), 64'(e.data));
            chk("beat_tlast", 64'(tlast), 64'(e.last));
            chk("beat_tuser", 64'(tuser), 64'(e.user));
            chk("beat_tid", 64'(tid), 64'(e.id));
            chk("beat_tdest", 64'(tdest), 64'(e.dest));
            chk("beat_tkeep", 64'(tkeep), 64'hF);
            chk("beat_tstrb", 64'(tstrb), 64'hF);
            chk("beat_pkt_done", 64'(sts_pkt_done), 64'(e.last));
          end
        end
        if (sts_pkt_done) done_cnt++;
        prev_stall = tvalid && !tready;
        h_data = tdata; h_last = tlast; h_user = tuser;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0; cfg_enable = 1'b0; cfg_pkt_len = '0; cfg_tid = '0; cfg_tdest = '0;
    res_valid = 1'b0; res_data = '0; tready = 1'b0;
`ifdef ACCEL_AXIS_PKT_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_res_ready", 64'(res_ready), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tuser", 64'(tuser), 64'd0);
    chk("rst_tkeep", 64'(tkeep), 64'd0);
    chk("rst_busy", 64'(sts_busy), 64'd0);
    chk("rst_pkt_done", 64'(sts_pkt_done), 64'd0);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("res_ready_after_rst", 64'(res_ready), 64'd1);
    tick();

    // Two 4-beat packets, plus pipeline latency on the first word.
    cfg_enable = 1'b1; cfg_pkt_len = 16'd4; cfg_tid = 8'd3; cfg_tdest = 4'd5; tready = 1'b1;
    d0 = done_cnt;
    push(32'h01, 1'b0, 8'd0, 8'd3, 4'd5);
    @(negedge clk);
    chk("lat_edge_n", 64'(tvalid), 64'd0);
    @(negedge clk);
    chk("lat_edge_n1", 64'(tvalid), 64'd0);
    chk("lat_busy", 64'(sts_busy), 64'd1);
    @(negedge clk);
    chk("lat_edge_n2", 64'(tvalid), 64'd1);
    tick();
    for (int i = 2; i <= 8; i++) begin
      push(32'(i), (i == 4 || i == 8), (i <= 4) ? 8'd0 : 8'd1, 8'd3, 4'd5);
    end
    wait_drain();
    chk("t1_pkt_done_pulses", 64'(done_cnt - d0), 64'd2);

    // Length 0 behaves as length 1.
    cfg_pkt_len = 16'd0;
    d0 = done_cnt;
    push(32'hDEADBEEF, 1'b1, 8'd2, 8'd3, 4'd5);
    wait_drain();
    chk("t2_pkt_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Backpressure: hold 10 cycles, then fill the FIFO to full.
    cfg_pkt_len = 16'd4;
    tready = 1'b0;
    d0 = done_cnt;
    push(32'h100, 1'b0, 8'd3, 8'd3, 4'd5);
    wait_tvalid();
    repeat (10) tick();
    push(32'h101, 1'b0, 8'd3, 8'd3, 4'd5);
    push(32'h102, 1'b0, 8'd3, 8'd3, 4'd5);
    push(32'h103, 1'b1, 8'd3, 8'd3, 4'd5);
    for (int i = 4; i <= 7; i++) begin
      push(32'h100 + 32'(i), (i == 7), 8'd4, 8'd3, 4'd5);
    end
    push(32'h108, 1'b0, 8'd5, 8'd3, 4'd5);
    @(negedge clk);
    chk("full_res_ready", 64'(res_ready), 64'd0);
    tick();
    res_valid = 1'b1; res_data = 32'h109;
    tick();
    @(negedge clk);
    chk("full_res_ready_held", 64'(res_ready), 64'd0);
    tick();
    tready = 1'b1;
    push(32'h109, 1'b0, 8'd5, 8'd3, 4'd5);
    push(32'h10A, 1'b0, 8'd5, 8'd3, 4'd5);
    push(32'h10B, 1'b1, 8'd5, 8'd3, 4'd5);
    wait_drain();
    chk("t3_pkt_done_pulses", 64'(done_cnt - d0), 64'd3);

    // Starved packet; mid-packet config/enable changes must not affect it.
    cfg_pkt_len = 16'd5; cfg_tid = 8'd9; cfg_tdest = 4'd2;
    d0 = done_cnt;
    push(32'h200, 1'b0, 8'd6, 8'd9, 4'd2);
    push(32'h201, 1'b0, 8'd6, 8'd9, 4'd2);
    push(32'h202, 1'b0, 8'd6, 8'd9, 4'd2);
    repeat (5) tick();
    cfg_tid = 8'd1; cfg_tdest = 4'd7; cfg_enable = 1'b0; cfg_pkt_len = 16'd1;
    repeat (15) tick();
    @(negedge clk);
    chk("gap_tvalid_low", 64'(tvalid), 64'd0);
    chk("gap_busy", 64'(sts_busy), 64'd1);
    tick();
    push(32'h203, 1'b0, 8'd6, 8'd9, 4'd2);
    push(32'h204, 1'b1, 8'd6, 8'd9, 4'd2);
    wait_drain();
    chk("gap_idle_after", 64'(sts_busy), 64'd0);
    push(32'h205, 1'b1, 8'd7, 8'd1, 4'd7);
    repeat (10) tick();
    @(negedge clk);
    chk("disabled_no_start", 64'(tvalid), 64'd0);
    chk("disabled_busy", 64'(sts_busy), 64'd0);
    tick();
    cfg_enable = 1'b1;
    wait_drain();
    chk("t4_pkt_done_pulses", 64'(done_cnt - d0), 64'd2);

    // Reset in the middle of a packet.
    cfg_pkt_len = 16'd4; cfg_tid = 8'd4; cfg_tdest = 4'd6;
    tready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h300 + 32'(i), (i == 3), 8'd8, 8'd4, 4'd6);
    wait_tvalid();
    tready = 1'b1;
    tick();
    tready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_tvalid", 64'(tvalid), 64'd0);
    chk("midrst_tuser", 64'(tuser), 64'd0);
    chk("midrst_busy", 64'(sts_busy), 64'd0);
    chk("midrst_res_ready", 64'(res_ready), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("postrst_res_ready", 64'(res_ready), 64'd1);
    chk("postrst_tvalid", 64'(tvalid), 64'd0);
    tick();
    tready = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(i), (i == 3), 8'd0, 8'd4, 4'd6);
    wait_drain();

`ifdef ACCEL_AXIS_PKT_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("stats_clr_pkt", 64'(sts_pkt_count), 64'd0);
    chk("stats_clr_word", 64'(sts_word_count), 64'd0);
    cfg_pkt_len = 16'd2;
    for (int i = 0; i < 6; i++) push(32'h500 + 32'(i), (i % 2 == 1), 8'(1 + i / 2), 8'd4, 4'd6);
    wait_drain();
    chk("stats_pkt_count", 64'(sts_pkt_count), 64'd3);
    chk("stats_word_count", 64'(sts_word_count), 64'd6);
    tready = 1'b0;
    push(32'h600, 1'b0, 8'd4, 8'd4, 4'd6);
    push(32'h601, 1'b1, 8'd4, 8'd4, 4'd6);
    wait_tvalid();
    tready = 1'b1;
    tick();
    tready = 1'b0;
    tick();
    tready = 1'b1;
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    @(negedge clk);
    chk("stats_clr_prio_pkt", 64'(sts_pkt_count), 64'd0);
    chk("stats_clr_prio_word", 64'(sts_word_count), 64'd0);
    tick();
    wait_drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
